wb_stage: RTL
=============

// Module: wb_stage
// PURPOSE
//  Final (write-back) pipeline stage; sits directly downstream of the MEM stage.
//  - Latches MEM results and the raw data-bus read word.
//  - Performs load byte/half/word extraction and LWL/LWR merging.
//  - Drives the GPR write port, the WB forwarding path to ID, and the WB exception-risk interlock.
// PARAMETERS
//  none (widths come from MyDefines.v)
// PORTS
//  clk                   in   1   single clock, all state on posedge
//  rst                   in   1   asynchronous reset, active-low
//  MEM_valid_w_i         in   1   MEM holds a finished instruction this cycle
//  REEXE_okToChange_w_i  in   1   partner-pipe interlock; 0 freezes WB
//  CP0_excOccur_w_i      in   1   exception taken this cycle
//  CP0_exceptSeg_w_i     in   EXCEP_SEG  stage mask; bit EXCEP_WB flushes this stage
//  data_rdata            in   32  data-bus read word, valid in the data_data_ok cycle
//  MEM_writeNum_i        in   GPR_NUM  destination GPR, 0 = no write
//  MEM_finalRes_i        in   32  ALU/MDU/CP0 result
//  MEM_loadSel_i         in   LOAD_SEL one-hot load kind
//  MEM_memReq_i          in   1   instruction is a load
//  MEM_alignCheck_i      in   2   VAddr[1:0]
//  MEM_rtData_i          in   32  old rt value, used for LWL/LWR merge
//  MEM_VAddr_i           in   32  instruction PC
//  MEM_isDangerous_i     in   1   dangerous-instruction flag
//  MEM_exceptionRisk_i   in   1   risk flag
//  WB_allowin_w_o        out  1   WB can accept this cycle
//  WB_hasRisk_w_o        out  1   registered exceptionRisk & hasData
//  WB_hasDangerous_w_o   out  1   registered isDangerous & hasData
//  WB_forwardMode_w_o    out  1   forward data valid (hasData)
//  WB_writeNum_w_o       out  GPR_NUM  forward destination
//  WB_forwardData_w_o    out  32  same value as WB_writeData_o
//  WB_writeEn_o          out  1   GPR write strobe
//  WB_writeNum_o         out  GPR_NUM  GPR address
//  WB_writeData_o        out  32  GPR data
//  debug_wb_pc/rf_wen[3:0]/rf_wnum[4:0]/rf_wdata  out  trace (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst=0, async): hasData=0, all stage registers 0. Every output 0 except WB_allowin_w_o=REEXE_okToChange_w_i.
//  - WB_allowin_w_o = REEXE_okToChange_w_i. WB never stalls on its own.
//  - needFlush = CP0_exceptSeg_w_i[EXCEP_WB] & CP0_excOccur_w_i.
//  - needUpdate = allowin & MEM_valid_w_i: load all regs; capture data_rdata into rdata_r only if MEM_memReq_i, else keep rdata_r.
//  - hasData: clears on needFlush or (allowin & !MEM_valid_w_i); otherwise set on needUpdate; holds when !allowin.
//    Flush has priority over update in the same cycle.
//  - Latency: 1 cycle. Captured at edge N; write visible during cycle N+1; regfile commits at edge N+1.
//  - WB_writeEn_o = hasData & writeNum!=0 & !needFlush & REEXE_okToChange_w_i. Held instruction writes exactly once:
//    - commit flag set on the first enabled cycle;
//    - commit flag cleared on the next update.
//  - Load select (a = alignCheck, b = byte lane a of rdata_r):
//    - LB/LBU: sign-/zero-extend b.
//    - LH/LHU: extend the half at a[1]. a[0] is guaranteed 0.
//    - LW: rdata_r.
//    - LWL: a=0 {rd[7:0],rt[23:0]}; 1 {rd[15:0],rt[15:0]}; 2 {rd[23:0],rt[7:0]}; 3 rd.
//    - LWR: a=0 rd; 1 {rt[31:24],rd[31:8]}; 2 {rt[31:16],rd[31:16]}; 3 {rt[31:8],rd[31:24]}.
//  - Non-load: writeData = finalRes.
//  - Zero or multiple loadSel bits on a load: result = rdata_r. The bench flags this as an illegal encoding.
//  - Reset mid-hold discards the instruction; no write is issued.
// CONFIGURATION
//  WB_DEBUG_TRACE_EN defined:
//    - debug_wb_pc = pc_r;
//    - debug_wb_rf_wen = {4{WB_writeEn_o}};
//    - debug_wb_rf_wnum = writeNum;
//    - debug_wb_rf_wdata = writeData.
//  Not defined: all debug_* tied to 0; no extra flops.
// STRUCTURE
//  - MyDefines.v (shared): LOAD_SEL with bit indices LOAD_LB/LBU/LH/LHU/LW_BIT/LWL/LWR; EXCEP_SEG and EXCEP_WB; GPR_NUM.
//  - One combinational sub-module: load_align (loadSel, align, rdata, rtData -> 32b result).
// TESTING
//  1. Hold rst=0 for 3 clks, release -> WB_writeEn_o=0 and all debug_*=0.
//  2. LB, align=2, rdata=0x12_85_34_56 -> writeData=0xFFFFFF85; LBU -> 0x00000085.
//  3. LWL align=1, rt=0xAABBCCDD, rdata=0x11223344 -> 0x3344CCDD; LWR align=1 -> 0xAA112233.
//  4. ALU result 0x5 to r3, then REEXE_okToChange low for 3 cycles -> exactly one writeEn pulse, r3=0x5.
//  5. needFlush in the cycle after capture -> no writeEn, hasData=0 next cycle, WB_hasRisk_w_o=0.
//  6. writeNum=0, finalRes=0xDEAD -> WB_writeEn_o stays 0; forwardMode=1, forwardData=0xDEAD.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared widths, load-select bit indices and exception-segment layout for the WB stage.
package wb_stage_pkg;
   localparam int LOAD_SEL    = 7;
   localparam int LOAD_LB     = 0;
   localparam int LOAD_LBU    = 1;
   localparam int LOAD_LH     = 2;
   localparam int LOAD_LHU    = 3;
   localparam int LOAD_LW_BIT = 4;
   localparam int LOAD_LWL    = 5;
   localparam int LOAD_LWR    = 6;

   localparam int EXCEP_SEG   = 5;
   localparam int EXCEP_WB    = 4;
   localparam int GPR_NUM     = 5;

   typedef logic [LOAD_SEL-1:0] load_sel_t;

   localparam load_sel_t SEL_LB  = load_sel_t'(1 << LOAD_LB);
   localparam load_sel_t SEL_LBU = load_sel_t'(1 << LOAD_LBU);
   localparam load_sel_t SEL_LH  = load_sel_t'(1 << LOAD_LH);
   localparam load_sel_t SEL_LHU = load_sel_t'(1 << LOAD_LHU);
   localparam load_sel_t SEL_LW  = load_sel_t'(1 << LOAD_LW_BIT);
   localparam load_sel_t SEL_LWL = load_sel_t'(1 << LOAD_LWL);
   localparam load_sel_t SEL_LWR = load_sel_t'(1 << LOAD_LWR);
endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load extraction: byte/half extension and LWL/LWR merge with the old rt value.
module wb_stage_load_align
   import wb_stage_pkg::*;
(
   input  logic [LOAD_SEL-1:0] load_sel,
   input  logic [1:0]          align,
   input  logic [31:0]         rdata,
   input  logic [31:0]         rt_data,
   output logic [31:0]         result
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      case (align)
         2'd0:    byte_lane = rdata[7:0];
         2'd1:    byte_lane = rdata[15:8];
         2'd2:    byte_lane = rdata[23:16];
         default: byte_lane = rdata[31:24];
      endcase
      half_lane = align[1] ? rdata[31:16] : rdata[15:0];

      // Illegal (zero or multi-hot) selects fall through to the raw word.
      result = rdata;
      case (load_sel)
         SEL_LB:  result = {{24{byte_lane[7]}}, byte_lane};
         SEL_LBU: result = {24'h0, byte_lane};
         SEL_LH:  result = {{16{half_lane[15]}}, half_lane};
         SEL_LHU: result = {16'h0, half_lane};
         SEL_LW:  result = rdata;
         SEL_LWL: begin
            case (align)
               2'd0:    result = {rdata[7:0],  rt_data[23:0]};
               2'd1:    result = {rdata[15:0], rt_data[15:0]};
               2'd2:    result = {rdata[23:0], rt_data[7:0]};
               default: result = rdata;
            endcase
         end
         SEL_LWR: begin
            case (align)
               2'd0:    result = rdata;
               2'd1:    result = {rt_data[31:24], rdata[31:8]};
               2'd2:    result = {rt_data[31:16], rdata[31:16]};
               default: result = {rt_data[31:8],  rdata[31:24]};
            endcase
         end
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: latches MEM results, aligns loads, drives the GPR write port and WB forwarding.
// Optional trace outputs enabled by defining WB_DEBUG_TRACE_EN.
module wb_stage
   import wb_stage_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 MEM_valid_w_i,
   input  logic                 REEXE_okToChange_w_i,
   input  logic                 CP0_excOccur_w_i,
   input  logic [EXCEP_SEG-1:0] CP0_exceptSeg_w_i,
   input  logic [31:0]          data_rdata,
   input  logic [GPR_NUM-1:0]   MEM_writeNum_i,
   input  logic [31:0]          MEM_finalRes_i,
   input  logic [LOAD_SEL-1:0]  MEM_loadSel_i,
   input  logic                 MEM_memReq_i,
   input  logic [1:0]           MEM_alignCheck_i,
   input  logic [31:0]          MEM_rtData_i,
   input  logic [31:0]          MEM_VAddr_i,
   input  logic                 MEM_isDangerous_i,
   input  logic                 MEM_exceptionRisk_i,
   output logic                 WB_allowin_w_o,
   output logic                 WB_hasRisk_w_o,
   output logic                 WB_hasDangerous_w_o,
   output logic                 WB_forwardMode_w_o,
   output logic [GPR_NUM-1:0]   WB_writeNum_w_o,
   output logic [31:0]          WB_forwardData_w_o,
   output logic                 WB_writeEn_o,
   output logic [GPR_NUM-1:0]   WB_writeNum_o,
   output logic [31:0]          WB_writeData_o,
   output logic [31:0]          debug_wb_pc,
   output logic [3:0]           debug_wb_rf_wen,
   output logic [4:0]           debug_wb_rf_wnum,
   output logic [31:0]          debug_wb_rf_wdata
);

   logic                has_data;
   logic                committed;
   logic                mem_req_r;
   logic                risk_r;
   logic                dangerous_r;
   logic [GPR_NUM-1:0]  write_num_r;
   logic [31:0]         final_res_r;
   logic [31:0]         rdata_r;
   logic [31:0]         rt_data_r;
   logic [LOAD_SEL-1:0] load_sel_r;
   logic [1:0]          align_r;
   logic [31:0]         load_result;
   logic [31:0]         write_data;
   logic                need_flush;
   logic                need_update;
   logic                unused_seg;

   assign unused_seg  = ^CP0_exceptSeg_w_i;
   assign need_flush  = CP0_exceptSeg_w_i[EXCEP_WB] & CP0_excOccur_w_i;
   assign need_update = REEXE_okToChange_w_i & MEM_valid_w_i;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         has_data    <= 1'b0;
         committed   <= 1'b0;
         mem_req_r   <= 1'b0;
         risk_r      <= 1'b0;
         dangerous_r <= 1'b0;
         write_num_r <= '0;
         final_res_r <= '0;
         rdata_r     <= '0;
         rt_data_r   <= '0;
         load_sel_r  <= '0;
         align_r     <= '0;
      end else begin
         if (need_flush || (REEXE_okToChange_w_i && !MEM_valid_w_i))
            has_data <= 1'b0;
         else if (need_update)
            has_data <= 1'b1;

         if (need_update) begin
            committed   <= 1'b0;
            mem_req_r   <= MEM_memReq_i;
            risk_r      <= MEM_exceptionRisk_i;
            dangerous_r <= MEM_isDangerous_i;
            write_num_r <= MEM_writeNum_i;
            final_res_r <= MEM_finalRes_i;
            rt_data_r   <= MEM_rtData_i;
            load_sel_r  <= MEM_loadSel_i;
            align_r     <= MEM_alignCheck_i;
            if (MEM_memReq_i)
               rdata_r <= data_rdata;
         end else if (WB_writeEn_o) begin
            committed <= 1'b1;
         end
      end
   end

   wb_stage_load_align u_load_align (
      .load_sel (load_sel_r),
      .align    (align_r),
      .rdata    (rdata_r),
      .rt_data  (rt_data_r),
      .result   (load_result)
   );

   assign write_data = mem_req_r ? load_result : final_res_r;

   assign WB_allowin_w_o      = REEXE_okToChange_w_i;
   assign WB_hasRisk_w_o      = risk_r & has_data;
   assign WB_hasDangerous_w_o = dangerous_r & has_data;
   assign WB_forwardMode_w_o  = has_data;
   assign WB_writeNum_w_o     = write_num_r;
   assign WB_forwardData_w_o  = write_data;
   // A held instruction may see several enabled cycles; committed limits it to one write.
   assign WB_writeEn_o        = has_data & (|write_num_r) & ~need_flush
                              & REEXE_okToChange_w_i & ~committed;
   assign WB_writeNum_o       = write_num_r;
   assign WB_writeData_o      = write_data;

`ifdef WB_DEBUG_TRACE_EN
   logic [31:0] pc_r;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         pc_r <= '0;
      else if (need_update)
         pc_r <= MEM_VAddr_i;
   end

   assign debug_wb_pc       = pc_r;
   assign debug_wb_rf_wen   = {4{WB_writeEn_o}};
   assign debug_wb_rf_wnum  = write_num_r;
   assign debug_wb_rf_wdata = write_data;
`else
   logic unused_vaddr;

   assign unused_vaddr      = ^MEM_VAddr_i;
   assign debug_wb_pc       = '0;
   assign debug_wb_rf_wen   = '0;
   assign debug_wb_rf_wnum  = '0;
   assign debug_wb_rf_wdata = '0;
`endif

endmodule
